// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl
// Read-side controller of an asynchronous FIFO built around dp_ram.
// Holds the binary/Gray read pointer, brings the write-domain Gray pointer
// across with a two-flop synchroniser, and derives empty, almost_empty and
// the fill level seen from the read clock domain.
//
// Ports
//   rd_clk        read-domain clock, all state on the rising edge
//   rd_rst_n      asynchronous active-low reset
//   rd_req        consumer asks to pop one word this cycle
//   wt_ptr_gray   write pointer (Gray, addr_width+1 bits) from the write domain
//   rd_en_dp_ram  read enable to dp_ram
//   rd_addr       read address to dp_ram
//   rd_ptr_gray   registered Gray read pointer, returned to the write domain
//   empty         no word available in the read domain view
//   almost_empty  rd_level <= almost_empty_thresh
//   rd_level      words available, 0 .. 2**addr_width
//   rd_valid      dp_ram data_out carries a freshly popped word this cycle
//   underflow     one-cycle pulse: rd_req arrived while empty
//
// Handshake: rd_req is a request, ~empty is the ready. A pop happens on a
// rising edge exactly when rd_req & ~empty (= rd_en_dp_ram) is high in the
// cycle before it; the popped word is presented with rd_valid one cycle later,
// matching dp_ram's registered output. A request while empty is dropped and
// flagged by underflow on the next cycle.
// -----------------------------------------------------------------------------
module fifo_rd_ctrl #(
  parameter int addr_width          = 4,
  parameter int almost_empty_thresh = 2
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  rd_req,
  input  logic [addr_width:0]   wt_ptr_gray,
  output logic                  rd_en_dp_ram,
  output logic [addr_width-1:0] rd_addr,
  output logic [addr_width:0]   rd_ptr_gray,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [addr_width:0]   rd_level,
  output logic                  rd_valid,
  output logic                  underflow
);

  localparam int PW = addr_width + 1;

  logic [PW-1:0] rd_ptr_bin_q,  rd_ptr_bin_d;
  logic [PW-1:0] rd_ptr_gray_q, rd_ptr_gray_d;
  logic [PW-1:0] wq1_q,         wq1_d;
  logic [PW-1:0] wq2_q,         wq2_d;
  logic          rd_valid_q,    rd_valid_d;
  logic          underflow_q,   underflow_d;

  logic          empty_c;
  logic          rd_en_c;
  logic [PW-1:0] wq2_bin_c;
  logic [PW-1:0] rd_level_c;

  // Gray to binary: each binary bit is the XOR of all Gray bits above and at it.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_comb begin
    // Comparing the registered Gray pointers directly keeps empty glitch-free
    // of any binary conversion and matches the write side's full compare.
    empty_c       = (rd_ptr_gray_q == wq2_q);
    rd_en_c       = rd_req & ~empty_c;

    rd_ptr_bin_d  = rd_ptr_bin_q + {{(PW-1){1'b0}}, rd_en_c};
    rd_ptr_gray_d = rd_ptr_bin_d ^ (rd_ptr_bin_d >> 1);

    // Plain two-flop chain; only wq2 is consumed downstream.
    wq1_d         = wt_ptr_gray;
    wq2_d         = wq1_q;

    // Modulo 2**PW difference; the extra MSB distinguishes full from empty.
    wq2_bin_c     = gray2bin(wq2_q);
    rd_level_c    = wq2_bin_c - rd_ptr_bin_q;

    rd_valid_d    = rd_en_c;
    underflow_d   = rd_req & empty_c;
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_ptr_bin_q  <= '0;
      rd_ptr_gray_q <= '0;
      wq1_q         <= '0;
      wq2_q         <= '0;
      rd_valid_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      rd_ptr_bin_q  <= rd_ptr_bin_d;
      rd_ptr_gray_q <= rd_ptr_gray_d;
      wq1_q         <= wq1_d;
      wq2_q         <= wq2_d;
      rd_valid_q    <= rd_valid_d;
      underflow_q   <= underflow_d;
    end
  end

  assign rd_en_dp_ram = rd_en_c;
  assign rd_addr      = rd_ptr_bin_q[addr_width-1:0];
  assign rd_ptr_gray  = rd_ptr_gray_q;
  assign empty        = empty_c;
  assign rd_level     = rd_level_c;
  assign almost_empty = (rd_level_c <= PW'(almost_empty_thresh));
  assign rd_valid     = rd_valid_q;
  assign underflow    = underflow_q;

endmodule
